i2c_peripheral_device: RTL
==========================

# i2c_peripheral_device

I2C target (peripheral) that answers the bus master on the shared `scl`/`sda` lines. It oversamples both lines on the local system clock, detects START/STOP, and matches a 7-bit address. Write bytes go out on a parallel receive port; bytes for read transfers come in on a parallel transmit port. The block sits on the same two-wire bus as the master device and is the other end of that protocol.

## Interface
- `ADDRESS`, 7'h42, 7-bit bus address this device answers to
- `clk` input 1: system clock; must be at least 10x the SCL frequency
- `rst` input 1: reset, asynchronous, active-high
- `scl` input 1: bus clock (the device never stretches SCL)
- `sda` inout 1: bus data, open-drain; the device drives only 0 or Z
- `tx_data` input 8: byte returned on a master read; sampled at each byte load
- `rx_data` output 8: last byte written by the master
- `rx_valid` output 1: one-clk pulse when `rx_data` updates
- `tx_req` output 1: one-clk pulse when `tx_data` has been loaded into the shifter
- `busy` output 1: high from an address match until STOP or NACK termination

## Operation
- Line conditioning:
  - `scl` and `sda` each pass through a 2-FF synchronizer.
  - A third register on each line provides rise/fall detection.
- Bus events:
  - START is `sda` falling while `scl` is high.
  - STOP is `sda` rising while `scl` is high.
  - Both are evaluated before any data-bit logic in the same clk.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- START from any state (repeated start included): go to ADDR, clear the bit counter, release `sda`.
- STOP from any state: go to IDLE, release `sda`, drop `busy`.
- ADDR:
  - Shift in 8 bits MSB first, sampling on each `scl` rise.
  - After bit 8, compare the upper 7 bits with `ADDRESS`.
  - Match: go to ADDR_ACK, `busy`=1.
  - Mismatch: go to WAIT_STOP and never drive `sda`.
- ADDR_ACK:
  - On the `scl` fall after bit 8, drive `sda`=0.
  - On the next `scl` fall, release `sda`.
  - rw=0: go to WRITE.
  - rw=1: load `tx_data`, pulse `tx_req`, drive bit 7, go to READ.
- WRITE:
  - Shift in 8 bits.
  - On the 8th `scl` rise, update `rx_data` and pulse `rx_valid`.
  - Go to WRITE_ACK: drive ACK for one SCL period, then return to WRITE.
- READ:
  - On each `scl` fall, present the next bit: 0 drives low, 1 releases.
  - After bit 0's `scl` fall, release `sda` and go to READ_ACK.
- READ_ACK, sample `sda` on the `scl` rise:
  - 0 (ACK): on the next `scl` fall, load `tx_data`, pulse `tx_req`, drive bit 7, go to READ.
  - 1 (NACK): go to WAIT_STOP, `busy`=0.
- WAIT_STOP: ignore bits; leave only on START or STOP.
- Bit counter is 4 bits (0..8) and wraps to 0 on every byte boundary.

## Timing
- Reset values:
  - `sda` released (Z)
  - `rx_data`=8'h00
  - `rx_valid`=0, `tx_req`=0, `busy`=0
  - state IDLE, counter 0
- Reset mid-transfer: immediate release of `sda`, state IDLE; no `rx_valid` pulse for the partial byte.
- Edge latency: a bus edge is acted on 3 clk after it reaches the pin (2 synchronizer stages + 1 detect).
- Drive timing: `sda` changes occur 3 clk after the `scl` fall, well inside the SCL low phase.
- `rx_valid` and `tx_req` are exactly one clk wide and never assert together.
- Simultaneous `scl` and `sda` edges in one clk: treated as a data edge, not START/STOP.

## Configuration
- `I2C_GENERAL_CALL_EN` defined:
  - Address 7'h00 with rw=0 is also matched, ACKed, and handled as WRITE.
  - 7'h00 with rw=1 is NACKed (WAIT_STOP).
- Macro undefined: 7'h00 is treated as a mismatch and never ACKed.

## Test plan
- Write 0x42+W, data 0xA5, STOP -> ACK low on both 9th clocks; `rx_data`=0xA5; one `rx_valid` pulse; `busy` falls after STOP.
- Address 0x17+W with ADDRESS=0x42 -> `sda` never driven; NACK seen by master; no `rx_valid`; `busy` stays 0.
- Read 0x42+R, `tx_data`=0x3C then 0xC3, master ACKs byte 1 and NACKs byte 2 -> bus shows 0x3C, 0xC3; two `tx_req` pulses; state WAIT_STOP then IDLE.
- Write 0x42+W, byte 0x11, repeated START, 0x42+R -> `rx_data`=0x11; read phase entered without STOP; ADDR re-matched.
- Assert `rst` during the 4th data bit of a write -> `sda` Z within the same clk; `rx_data` unchanged at 0x00; next START/0x42+W is ACKed normally.
- General call 0x00+W, data 0x06 -> with `I2C_GENERAL_CALL_EN` defined: ACK and `rx_data`=0x06; with it undefined: NACK and no `rx_valid`.

Source files
------------

// File: rtl/i2c_peripheral_device.sv
// I2C target with an oversampled SCL/SDA front end, 7-bit address match, and parallel rx/tx byte ports.
// Optional: define I2C_GENERAL_CALL_EN to also accept the general-call address (7'h00, write only).
module i2c_peripheral_device #(
    parameter logic [6:0] ADDRESS = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(7);
    localparam logic [CNT_W-1:0] BYTE_DONE = CNT_W'(8);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t           state_q;
    logic [2:0]       scl_q;
    logic [2:0]       sda_q;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       shift_q;
    logic [7:0]       tx_sr_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             tx_req_q;
    logic             busy_q;
    logic             sda_oe_q;
    logic             ack_q;
    logic             rw_q;

    logic scl_rise, scl_fall, sda_rise, sda_fall, scl_hold_hi;
    logic start_det, stop_det, addr_match;

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

    // Two synchronizer stages plus one history stage per line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_rise    =  scl_q[1] & ~scl_q[2];
    assign scl_fall    = ~scl_q[1] &  scl_q[2];
    assign sda_rise    =  sda_q[1] & ~sda_q[2];
    assign sda_fall    = ~sda_q[1] &  sda_q[2];
    // SCL must be steadily high, so a coincident SCL edge makes this a data edge
    assign scl_hold_hi =  scl_q[1] &  scl_q[2];
    assign start_det   = sda_fall & scl_hold_hi;
    assign stop_det    = sda_rise & scl_hold_hi;

    // shift_q holds address bits 7..1 when the rw bit is on the line
    always_comb begin
        addr_match = (shift_q == ADDRESS);
`ifdef I2C_GENERAL_CALL_EN
        if ((shift_q == 7'h00) && !sda_q[1]) begin
            addr_match = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_sr_q    <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (start_det) begin
                state_q  <= ADDR;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
                ack_q    <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
                ack_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[5:0], sda_q[1]};
                            if (cnt_q == LAST_BIT) begin
                                cnt_q <= '0;
                                if (addr_match) begin
                                    state_q <= ADDR_ACK;
                                    busy_q  <= 1'b1;
                                    rw_q    <= sda_q[1];
                                end else begin
                                    state_q <= WAIT_STOP;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    // First SCL fall drives ACK, second releases it and enters the data phase
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_q) begin
                                sda_oe_q <= 1'b1;
                                ack_q    <= 1'b1;
                            end else begin
                                ack_q <= 1'b0;
                                if (!rw_q) begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= WRITE;
                                end else begin
                                    tx_sr_q  <= {tx_data[6:0], 1'b0};
                                    sda_oe_q <= ~tx_data[7];
                                    tx_req_q <= 1'b1;
                                    cnt_q    <= CNT_W'(1);
                                    state_q  <= READ;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[5:0], sda_q[1]};
                            if (cnt_q == LAST_BIT) begin
                                rx_data_q  <= {shift_q, sda_q[1]};
                                rx_valid_q <= 1'b1;
                                cnt_q      <= '0;
                                ack_q      <= 1'b0;
                                state_q    <= WRITE_ACK;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!ack_q) begin
                                sda_oe_q <= 1'b1;
                                ack_q    <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                ack_q    <= 1'b0;
                                state_q  <= WRITE;
                            end
                        end
                    end
                    // cnt_q counts bits already presented; bit 7 went out at load time
                    READ: begin
                        if (scl_fall) begin
                            if (cnt_q == BYTE_DONE) begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= '0;
                                ack_q    <= 1'b0;
                                state_q  <= READ_ACK;
                            end else begin
                                sda_oe_q <= ~tx_sr_q[7];
                                tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
                                cnt_q    <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_q[1]) begin
                                state_q <= WAIT_STOP;
                                busy_q  <= 1'b0;
                            end else begin
                                ack_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_q) begin
                            ack_q    <= 1'b0;
                            tx_sr_q  <= {tx_data[6:0], 1'b0};
                            sda_oe_q <= ~tx_data[7];
                            tx_req_q <= 1'b1;
                            cnt_q    <= CNT_W'(1);
                            state_q  <= READ;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
